fnd_scan_controller: RTL

Time-multiplexed scan controller for the 4-digit FND (7-segment) display. It divides the system clock into a digit-scan tick and steps the 2-bit digit position. It double-buffers the displayed value, so a new value is shown only from digit 0 of a frame. It decodes each digit to active-low segment and common drive, and sits between the timer/motor-status logic and the board's FND pins.

---
 rtl/fnd_scan_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fnd_scan_controller.sv
// 4-digit FND scan controller: prescaled digit scan, double-buffered value.
// Optional blink via FND_BLINK_EN (frame counter + per-digit mask).
module fnd_scan_controller #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_value,
  input  logic        i_load,
  output logic        o_load_ack,
  input  logic        i_blank_lz,
  input  logic [3:0]  i_dp,
  input  logic [3:0]  i_blink_mask,
  output logic [3:0]  o_com,
  output logic [7:0]  o_seg,
  output logic        o_frame
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc;
  logic [1:0]    pos;
  logic [15:0]   shadow;
  logic [15:0]   staging;
  logic          pending;
  logic          fb_q;

  logic          tick;
  logic          fb;
  logic          commit;
  logic          blink_off;
  logic          lz;
  logic          blank;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic [3:0]    com_nx;
  logic [7:0]    seg_nx;

  assign tick   = (presc == PW'(SCAN_DIV - 1));
  assign fb     = tick && (pos == 2'd3);
  assign commit = fb && (pending || i_load);

`ifdef FND_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] fcnt;
  logic          phase_on;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fcnt     <= '0;
      phase_on <= 1'b1;
    end else if (fb) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt     <= '0;
        phase_on <= ~phase_on;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign blink_off = !phase_on && i_blink_mask[pos];
`else
  localparam int unused_bf = BLINK_FRAMES;
  logic unused_blink;
  assign unused_blink = ^{i_blink_mask, unused_bf[0]};
  assign blink_off    = 1'b0;
`endif

  always_comb begin
    nib = shadow[{pos, 2'b00} +: 4];
    lz  = 1'b0;
    unique case (pos)
      2'd0: lz = 1'b0;
      2'd1: lz = (shadow[15:4] == '0);
      2'd2: lz = (shadow[15:8] == '0);
      2'd3: lz = (shadow[15:12] == '0);
    endcase
    blank = i_blank_lz && lz;
  end

  // {g,f,e,d,c,b,a}, active-low; 6, 7 and 9 carry tails
  always_comb begin
    glyph = 7'h7F;
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h58;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  end

  always_comb begin
    com_nx = 4'b1111 ^ (4'b0001 << pos);
    if (blink_off) com_nx[pos] = 1'b1;
    seg_nx = {~i_dp[pos], blank ? 7'h7F : glyph};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc      <= '0;
      pos        <= 2'd0;
      shadow     <= '0;
      staging    <= '0;
      pending    <= 1'b0;
      fb_q       <= 1'b0;
      o_com      <= 4'b1111;
      o_seg      <= 8'hFF;
      o_load_ack <= 1'b0;
      o_frame    <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pos <= pos + 2'd1;
      // a load on the boundary bypasses staging
      if (fb) begin
        if (i_load)       shadow <= i_value;
        else if (pending) shadow <= staging;
        pending <= 1'b0;
      end else if (i_load) begin
        pending <= 1'b1;
      end
      if (i_load) staging <= i_value;
      o_load_ack <= commit;
      fb_q       <= fb;
      o_frame    <= fb_q;
      o_com      <= com_nx;
      o_seg      <= seg_nx;
    end
  end

endmodule
